// File: rtl/pipelined_datapath_fwd.sv
// rtl/pipelined_datapath_fwd.sv - five-stage datapath with valid bits, register file, EX forwarding and hazard stalls
// The control decoder is external: it decodes id_instr and drives the control inputs for the ID instruction.
module pipelined_datapath_fwd #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                instr,
  input  logic                       instr_valid,
  input  logic                       RegDst,
  input  logic                       RegWr,
  input  logic                       ALUsrc,
  input  logic                       MemWr,
  input  logic                       MemToReg,
  input  logic [1:0]                 ALUcntrl,
  output logic [31:0]                id_instr,
  output logic                       stall,
  output logic [WIDTH-1:0]           seOut,
  output logic [WIDTH-1:0]           reg_Da,
  output logic [WIDTH-1:0]           dmem_addr,
  output logic [WIDTH-1:0]           dmem_wdata,
  output logic                       dmem_we,
  input  logic [WIDTH-1:0]           dmem_rdata,
  output logic                       wb_valid,
  output logic [$clog2(NREGS)-1:0]   wb_addr,
  output logic [WIDTH-1:0]           wb_data
);

  localparam int AW = $clog2(NREGS);

  // IF/ID
  logic [31:0]      ifid_instr_q;
  logic             ifid_v_q;

  // register file
  logic [WIDTH-1:0] rf_q [NREGS];

  // ID/EX
  logic [WIDTH-1:0] idex_da_q, idex_db_q, idex_se_q;
  logic [AW-1:0]    idex_aw_q, idex_rs_q, idex_rt_q;
  logic             idex_regwr_q, idex_memwr_q, idex_memtoreg_q, idex_alusrc_q, idex_v_q;
  logic [1:0]       idex_aluc_q;

  // EX/MEM
  logic [WIDTH-1:0] exmem_alu_q, exmem_wdata_q;
  logic [AW-1:0]    exmem_aw_q;
  logic             exmem_regwr_q, exmem_memwr_q, exmem_memtoreg_q, exmem_v_q;

  // MEM/WB
  logic [WIDTH-1:0] memwb_data_q;
  logic [AW-1:0]    memwb_aw_q;
  logic             memwb_regwr_q, memwb_v_q;

  // ID stage decode
  logic [AW-1:0]    rs_a, rt_a, rd_a, id_aw;
  logic [WIDTH-1:0] id_da, id_db, id_se;
  logic             use_rt, idex_v_d;

  assign rs_a   = ifid_instr_q[21 +: AW];
  assign rt_a   = ifid_instr_q[16 +: AW];
  assign rd_a   = ifid_instr_q[11 +: AW];
  assign id_aw  = RegDst ? rd_a : rt_a;
  assign use_rt = !ALUsrc || MemWr;

  always_comb begin
    id_se       = {WIDTH{ifid_instr_q[15]}};
    id_se[15:0] = ifid_instr_q[15:0];
  end

  // write-before-read: a retiring WB result is visible to the ID read in the same cycle
  always_comb begin
    id_da = rf_q[rs_a];
    id_db = rf_q[rt_a];
    if (wb_valid && (wb_addr == rs_a)) id_da = wb_data;
    if (wb_valid && (wb_addr == rt_a)) id_db = wb_data;
  end

  // hazard detection
  logic hit_idex, hit_exmem, load_use;

  always_comb begin
    hit_idex  = idex_v_q && idex_regwr_q && (idex_aw_q != '0) &&
                ((rs_a == idex_aw_q) || (use_rt && (rt_a == idex_aw_q)));
    hit_exmem = exmem_v_q && exmem_regwr_q && (exmem_aw_q != '0) &&
                ((rs_a == exmem_aw_q) || (use_rt && (rt_a == exmem_aw_q)));
    load_use  = hit_idex && idex_memtoreg_q;
    if (FWD_EN) stall = ifid_v_q && load_use;
    else        stall = ifid_v_q && (hit_idex || hit_exmem);
  end

  assign idex_v_d = ifid_v_q && !stall;

  // EX stage forwarding; loads in EX/MEM are excluded because their data is not ready yet
  logic             fa_exmem, fa_memwb, fb_exmem, fb_memwb;
  logic [WIDTH-1:0] ex_a, ex_b_fwd, ex_b, ex_alu;

  always_comb begin
    fa_exmem = exmem_v_q && exmem_regwr_q && !exmem_memtoreg_q &&
               (exmem_aw_q != '0) && (exmem_aw_q == idex_rs_q);
    fb_exmem = exmem_v_q && exmem_regwr_q && !exmem_memtoreg_q &&
               (exmem_aw_q != '0) && (exmem_aw_q == idex_rt_q);
    fa_memwb = memwb_v_q && memwb_regwr_q && (memwb_aw_q != '0) && (memwb_aw_q == idex_rs_q);
    fb_memwb = memwb_v_q && memwb_regwr_q && (memwb_aw_q != '0) && (memwb_aw_q == idex_rt_q);
    ex_a     = idex_da_q;
    ex_b_fwd = idex_db_q;
    if (FWD_EN) begin
      if (fa_exmem)      ex_a = exmem_alu_q;
      else if (fa_memwb) ex_a = memwb_data_q;
      if (fb_exmem)      ex_b_fwd = exmem_alu_q;
      else if (fb_memwb) ex_b_fwd = memwb_data_q;
    end
  end

  assign ex_b = idex_alusrc_q ? idex_se_q : ex_b_fwd;

  always_comb begin
    ex_alu = '0;
    case (idex_aluc_q)
      2'b00:   ex_alu = ex_a + ex_b;
      2'b01:   ex_alu = ex_a - ex_b;
      2'b10:   ex_alu = ex_a & ex_b;
      default: ex_alu = ex_a | ex_b;
    endcase
  end

  // IF/ID register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_instr_q <= '0;
      ifid_v_q     <= 1'b0;
    end else if (!stall) begin
      ifid_instr_q <= instr;
      ifid_v_q     <= instr_valid;
    end
  end

  // ID/EX register; a stall turns this slot into a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_da_q       <= '0;
      idex_db_q       <= '0;
      idex_se_q       <= '0;
      idex_aw_q       <= '0;
      idex_rs_q       <= '0;
      idex_rt_q       <= '0;
      idex_regwr_q    <= 1'b0;
      idex_memwr_q    <= 1'b0;
      idex_memtoreg_q <= 1'b0;
      idex_alusrc_q   <= 1'b0;
      idex_aluc_q     <= 2'b00;
      idex_v_q        <= 1'b0;
    end else begin
      idex_da_q       <= id_da;
      idex_db_q       <= id_db;
      idex_se_q       <= id_se;
      idex_aw_q       <= id_aw;
      idex_rs_q       <= rs_a;
      idex_rt_q       <= rt_a;
      idex_regwr_q    <= RegWr && idex_v_d;
      idex_memwr_q    <= MemWr && idex_v_d;
      idex_memtoreg_q <= MemToReg;
      idex_alusrc_q   <= ALUsrc;
      idex_aluc_q     <= ALUcntrl;
      idex_v_q        <= idex_v_d;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_alu_q      <= '0;
      exmem_wdata_q    <= '0;
      exmem_aw_q       <= '0;
      exmem_regwr_q    <= 1'b0;
      exmem_memwr_q    <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_v_q        <= 1'b0;
    end else begin
      exmem_alu_q      <= ex_alu;
      exmem_wdata_q    <= ex_b_fwd;
      exmem_aw_q       <= idex_aw_q;
      exmem_regwr_q    <= idex_regwr_q && idex_v_q;
      exmem_memwr_q    <= idex_memwr_q && idex_v_q;
      exmem_memtoreg_q <= idex_memtoreg_q;
      exmem_v_q        <= idex_v_q;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memwb_data_q  <= '0;
      memwb_aw_q    <= '0;
      memwb_regwr_q <= 1'b0;
      memwb_v_q     <= 1'b0;
    end else begin
      memwb_data_q  <= exmem_memtoreg_q ? dmem_rdata : exmem_alu_q;
      memwb_aw_q    <= exmem_aw_q;
      memwb_regwr_q <= exmem_regwr_q && exmem_v_q;
      memwb_v_q     <= exmem_v_q;
    end
  end

  // register file; wb_valid already excludes r0 so it always reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_valid) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign id_instr   = ifid_instr_q;
  assign seOut      = idex_se_q;
  assign reg_Da     = ex_a;
  assign dmem_addr  = exmem_alu_q;
  assign dmem_wdata = exmem_wdata_q;
  assign dmem_we    = exmem_v_q && exmem_memwr_q;
  assign wb_valid   = memwb_v_q && memwb_regwr_q && (memwb_aw_q != '0);
  assign wb_addr    = memwb_aw_q;
  assign wb_data    = memwb_data_q;

endmodule

// File: tb/tb_pipelined_datapath_fwd.sv
// tb/tb_pipelined_datapath_fwd.sv - scoreboard bench for pipelined_datapath_fwd (forwarding and stall-only instances)
module tb_pipelined_datapath_fwd;

  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        sel;
  always #5 clk = ~clk;

  // per-instance signals: _f forwarding, _n stall-only
  logic        iv_f, iv_n;
  logic [6:0]  ctrl_f, ctrl_n;
  logic [31:0] id_instr_f, id_instr_n, seOut_f, seOut_n, reg_Da_f, reg_Da_n;
  logic [31:0] daddr_f, daddr_n, dwdata_f, dwdata_n, drdata_f, drdata_n, wb_data_f, wb_data_n;
  logic        stall_f, stall_n, dwe_f, dwe_n, wb_valid_f, wb_valid_n;
  logic [4:0]  wb_addr_f, wb_addr_n;

  function automatic logic [6:0] decode(input logic [31:0] i);
    // {RegDst, RegWr, ALUsrc, MemWr, MemToReg, ALUcntrl}
    logic [6:0] c;
    c = 7'b0;
    case (i[31:26])
      6'h00: case (i[5:0])
        F_ADD:   c = 7'b11000_00;
        F_SUB:   c = 7'b11000_01;
        F_AND:   c = 7'b11000_10;
        F_OR:    c = 7'b11000_11;
        default: c = 7'b0;
      endcase
      OP_ADDI: c = 7'b01100_00;
      OP_LW:   c = 7'b01101_00;
      OP_SW:   c = 7'b00110_00;
      default: c = 7'b0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  assign iv_f   = instr_valid && !sel;
  assign iv_n   = instr_valid && sel;
  assign ctrl_f = decode(id_instr_f);
  assign ctrl_n = decode(id_instr_n);

  pipelined_datapath_fwd #(.WIDTH(32), .NREGS(32), .FWD_EN(1'b1)) dut_f (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(iv_f),
    .RegDst(ctrl_f[6]), .RegWr(ctrl_f[5]), .ALUsrc(ctrl_f[4]), .MemWr(ctrl_f[3]),
    .MemToReg(ctrl_f[2]), .ALUcntrl(ctrl_f[1:0]),
    .id_instr(id_instr_f), .stall(stall_f), .seOut(seOut_f), .reg_Da(reg_Da_f),
    .dmem_addr(daddr_f), .dmem_wdata(dwdata_f), .dmem_we(dwe_f), .dmem_rdata(drdata_f),
    .wb_valid(wb_valid_f), .wb_addr(wb_addr_f), .wb_data(wb_data_f)
  );

  pipelined_datapath_fwd #(.WIDTH(32), .NREGS(32), .FWD_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(iv_n),
    .RegDst(ctrl_n[6]), .RegWr(ctrl_n[5]), .ALUsrc(ctrl_n[4]), .MemWr(ctrl_n[3]),
    .MemToReg(ctrl_n[2]), .ALUcntrl(ctrl_n[1:0]),
    .id_instr(id_instr_n), .stall(stall_n), .seOut(seOut_n), .reg_Da(reg_Da_n),
    .dmem_addr(daddr_n), .dmem_wdata(dwdata_n), .dmem_we(dwe_n), .dmem_rdata(drdata_n),
    .wb_valid(wb_valid_n), .wb_addr(wb_addr_n), .wb_data(wb_data_n)
  );

  // combinational data memory shared by both instances
  logic [31:0] mem [16];
  assign drdata_f = mem[daddr_f[5:2]];
  assign drdata_n = mem[daddr_n[5:2]];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    end else begin
      if (dwe_f) mem[daddr_f[5:2]] = dwdata_f;
      if (dwe_n) mem[daddr_n[5:2]] = dwdata_n;
    end
  end

  // observed instance
  logic        stall_s, dwe_s, wb_valid_s;
  logic [4:0]  wb_addr_s;
  logic [31:0] wb_data_s, seOut_s, reg_Da_s, daddr_s, dwdata_s;
  always_comb begin
    stall_s    = sel ? stall_n    : stall_f;
    dwe_s      = sel ? dwe_n      : dwe_f;
    wb_valid_s = sel ? wb_valid_n : wb_valid_f;
    wb_addr_s  = sel ? wb_addr_n  : wb_addr_f;
    wb_data_s  = sel ? wb_data_n  : wb_data_f;
    seOut_s    = sel ? seOut_n    : seOut_f;
    reg_Da_s   = sel ? reg_Da_n   : reg_Da_f;
    daddr_s    = sel ? daddr_n    : daddr_f;
    dwdata_s   = sel ? dwdata_n   : dwdata_f;
  end

  typedef struct packed { logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t        sb_q[$];
  int          ret_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, acc_cyc = 0, stall_cnt = 0, we_cnt = 0;
  logic [31:0] we_addr, we_data;

  always @(posedge clk) cyc++;

  // scoreboard: every retire is popped and compared
  always @(negedge clk) begin
    exp_t e;
    if (stall_s) stall_cnt++;
    if (dwe_s) begin
      we_cnt++;
      we_addr = daddr_s;
      we_data = dwdata_s;
    end
    if (wb_valid_s) begin
      ret_q.push_back(cyc);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL retire_unexpected: got r%0d=%h, required no retire", wb_addr_s, wb_data_s);
      end else begin
        e = sb_q.pop_front();
        if ({wb_addr_s, wb_data_s} !== {e.a, e.d}) begin
          n_bad++;
          $display("FAIL retire: got r%0d=%h, required r%0d=%h", wb_addr_s, wb_data_s, e.a, e.d);
        end
      end
    end
  end

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ins);
    int g;
    g = 0;
    instr       = ins;
    instr_valid = 1'b1;
    while (stall_s && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (g >= 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: stall held %0d cycles, required release", g);
    end
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic drain();
    int g;
    g = 0;
    instr_valid = 1'b0;
    while (sb_q.size() != 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d retires outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sel = 1'b0; instr = 32'd0; instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({stall_f, dwe_f, wb_valid_f} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b, required 000", {stall_f, dwe_f, wb_valid_f});
    end
    n_cmp++;
    if ({id_instr_f, seOut_f, reg_Da_f, daddr_f, wb_data_f} !== 160'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h, required 0", {id_instr_f, seOut_f, reg_Da_f, daddr_f, wb_data_f});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int a1;
    sel = 1'b0; stall_cnt = 0; ret_q.delete();
    push(5'd1, 32'd5); push(5'd2, 32'd8);
    issue(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5));
    a1 = acc_cyc;
    issue(enc_i(OP_ADDI, 5'd1, 5'd2, 16'd3));
    drain();
    n_cmp++;
    if (stall_cnt !== 0) begin n_bad++; $display("FAIL b2b_stall: got %0d, required 0", stall_cnt); end
    n_cmp++;
    if (ret_q.size() != 2 || ret_q[0] - a1 != 3) begin
      n_bad++; $display("FAIL b2b_latency: got %0d, required 3", ret_q[0] - a1);
    end
    n_cmp++;
    if (ret_q.size() != 2 || ret_q[1] - a1 != 4) begin
      n_bad++; $display("FAIL b2b_total: got %0d, required 4", ret_q[1] - a1);
    end
  endtask

  task automatic test_load_use();
    sel = 1'b0; stall_cnt = 0; we_cnt = 0;
    push(5'd3, 32'd8); push(5'd4, 32'd16);
    issue(enc_i(OP_SW, 5'd0, 5'd2, 16'd0));
    issue(enc_i(OP_LW, 5'd0, 5'd3, 16'd0));
    issue(enc_r(5'd3, 5'd3, 5'd4, F_ADD));
    drain();
    n_cmp++;
    if (we_cnt !== 1) begin n_bad++; $display("FAIL lu_we_count: got %0d, required 1", we_cnt); end
    n_cmp++;
    if ({we_addr, we_data} !== {32'd0, 32'd8}) begin
      n_bad++; $display("FAIL lu_store: got addr %h data %h, required 0 / 8", we_addr, we_data);
    end
    n_cmp++;
    if (stall_cnt !== 1) begin n_bad++; $display("FAIL lu_stall: got %0d, required 1", stall_cnt); end
  endtask

  task automatic test_sign_ext();
    sel = 1'b0;
    push(5'd5, 32'hFFFF_FFFF); push(5'd6, 32'd1);
    issue(enc_i(OP_ADDI, 5'd0, 5'd5, 16'hFFFF));
    issue(enc_r(5'd0, 5'd5, 5'd6, F_SUB));
    n_cmp++;
    if (seOut_s !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL se_out: got %h, required ffffffff", seOut_s);
    end
    drain();
  endtask

  task automatic test_r0_write();
    sel = 1'b0; stall_cnt = 0; ret_q.delete();
    push(5'd7, 32'd0);
    issue(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7));
    issue(enc_r(5'd0, 5'd0, 5'd7, F_ADD));
    instr_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (reg_Da_s !== 32'd0) begin n_bad++; $display("FAIL r0_fwd: got %h, required 0", reg_Da_s); end
    drain();
    n_cmp++;
    if (stall_cnt !== 0 || ret_q.size() != 1) begin
      n_bad++; $display("FAIL r0_retire: got stalls %0d retires %0d, required 0 / 1", stall_cnt, ret_q.size());
    end
  endtask

  task automatic test_no_forwarding();
    int a1;
    sel = 1'b1; stall_cnt = 0; ret_q.delete();
    push(5'd1, 32'd5); push(5'd2, 32'd8);
    issue(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5));
    a1 = acc_cyc;
    issue(enc_i(OP_ADDI, 5'd1, 5'd2, 16'd3));
    drain();
    n_cmp++;
    if (stall_cnt !== 2) begin n_bad++; $display("FAIL nofwd_stall: got %0d, required 2", stall_cnt); end
    n_cmp++;
    if (ret_q.size() != 2 || ret_q[0] - a1 != 3) begin
      n_bad++; $display("FAIL nofwd_first: got %0d, required 3", ret_q[0] - a1);
    end
    n_cmp++;
    if (ret_q.size() != 2 || ret_q[1] - a1 != 6) begin
      n_bad++; $display("FAIL nofwd_total: got %0d, required 6", ret_q[1] - a1);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    push(5'd8, 32'd1); push(5'd9, 32'd2); push(5'd10, 32'd3);
    issue(enc_i(OP_ADDI, 5'd0, 5'd8, 16'd1));
    issue(enc_i(OP_ADDI, 5'd0, 5'd9, 16'd2));
    issue(enc_i(OP_ADDI, 5'd0, 5'd10, 16'd3));
    instr_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({stall_f, dwe_f, wb_valid_f} !== 3'b000) begin
      n_bad++; $display("FAIL midrst_strobes: got %b, required 000", {stall_f, dwe_f, wb_valid_f});
    end
    n_cmp++;
    if ({id_instr_f, seOut_f, reg_Da_f, daddr_f, wb_data_f} !== 160'd0) begin
      n_bad++; $display("FAIL midrst_data: got %h, required 0", {id_instr_f, seOut_f, reg_Da_f, daddr_f, wb_data_f});
    end
    sb_q.delete();
    ret_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (ret_q.size() != 0) begin
      n_bad++; $display("FAIL midrst_quiet: got %0d retires, required 0", ret_q.size());
    end
    push(5'd11, 32'd0);
    issue(enc_r(5'd1, 5'd2, 5'd11, F_ADD));
    drain();
    n_cmp++;
    if (ret_q.size() != 1) begin
      n_bad++; $display("FAIL midrst_after: got %0d retires, required 1", ret_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_sign_ext();
    test_r0_write();
    test_no_forwarding();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
